// File: rtl/lfsr_fibonacci_checker_pkg.sv
// Shared types and mask table for the Fibonacci LFSR generator/checker.
// mask_lookup maps (length, n_taps) to {valid, tap mask}.
package lfsr_fibonacci_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEED   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] mask;
  } mask_t;

  function automatic mask_t mask_lookup(
    input logic [2:0] len,
    input logic       n_taps
  );
    mask_t m;
    m = '0;
    if (!n_taps) begin
      unique case (len)
        3'd2:    m = '{1'b1, 8'h03};
        3'd3:    m = '{1'b1, 8'h06};
        3'd4:    m = '{1'b1, 8'h0C};
        3'd5:    m = '{1'b1, 8'h14};
        3'd6:    m = '{1'b1, 8'h30};
        3'd7:    m = '{1'b1, 8'h60};
        default: m = '0;
      endcase
    end else begin
      unique case (len)
        3'd5:    m = '{1'b1, 8'h1E};
        3'd6:    m = '{1'b1, 8'h36};
        3'd7:    m = '{1'b1, 8'h78};
        default: m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr_fibonacci_checker_mask_select.sv
// Combinational tap-mask lookup shared by LFSR generator and checker.
// Ports: len_i, n_taps_i in; valid_o, mask_o out.
module lfsr_fibonacci_checker_mask_select
  import lfsr_fibonacci_checker_pkg::*;
(
  input  logic [2:0] len_i,
  input  logic       n_taps_i,
  output logic       valid_o,
  output logic [7:0] mask_o
);

  mask_t m;

  always_comb begin
    m       = mask_lookup(len_i, n_taps_i);
    valid_o = m.valid;
    mask_o  = m.mask;
  end

endmodule

// File: rtl/lfsr_fibonacci_checker.sv
// Self-synchronising serial checker for a Fibonacci LFSR bit stream.
// In: clk, rst_n, bit_in/bit_valid, lfsr_length/n_taps, err_clr.
// Out: cfg_valid, locked, err_pulse, err_count, bit_count, state.
module lfsr_fibonacci_checker
  import lfsr_fibonacci_checker_pkg::*;
#(
  parameter int LOCK_RUN    = 8,
  parameter int GOOD_RUN    = 16,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic [2:0]       lfsr_length,
  input  logic             lfsr_n_taps,
  input  logic             err_clr,
  output logic             cfg_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic [1:0]       state
);

  localparam int RUN_MAX =
    (LOCK_RUN > GOOD_RUN) ? LOCK_RUN : GOOD_RUN;
  localparam int RUN_W  = $clog2(RUN_MAX + 1);
  localparam int MISS_W = $clog2(LOSS_THRESH + 1);

  logic             sel_valid;
  logic [7:0]       sel_mask;

  logic [2:0]       len_q, len_d;
  logic             ntaps_q, ntaps_d;
  logic             vld_q, vld_d;
  logic [7:0]       mask_q, mask_d;
  logic [7:0]       s_q, s_d;
  state_e           state_q, state_d;
  logic [2:0]       seed_q, seed_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             pulse_q, pulse_d;

  logic             cfg_chg;
  logic [7:0]       s_upd;
  logic [7:0]       lmask;
  logic             bad;
  logic [2:0]       seed_inc;
  logic [RUN_W-1:0] run_inc;
  logic [MISS_W-1:0] miss_inc;
  logic [CNT_W-1:0] err_inc;
  logic [CNT_W-1:0] bcnt_inc;

  lfsr_fibonacci_checker_mask_select u_sel (
    .len_i    (lfsr_length),
    .n_taps_i (lfsr_n_taps),
    .valid_o  (sel_valid),
    .mask_o   (sel_mask)
  );

  always_comb begin
    cfg_chg  = (lfsr_length != len_q) ||
               (lfsr_n_taps != ntaps_q);
    s_upd    = {s_q[6:0], bit_in};
    lmask    = ~(8'hFF << len_q);
    // All-zero window can never come from a live LFSR.
    bad      = ((^(s_q & mask_q)) != bit_in) ||
               ((s_upd & lmask) == 8'h00);
    seed_inc = seed_q + 3'd1;
    run_inc  = run_q + RUN_W'(1);
    miss_inc = miss_q + MISS_W'(1);
    err_inc  = (err_q == '1) ? err_q
                             : err_q + CNT_W'(1);
    bcnt_inc = (bcnt_q == '1) ? bcnt_q
                              : bcnt_q + CNT_W'(1);
  end

  always_comb begin
    len_d   = lfsr_length;
    ntaps_d = lfsr_n_taps;
    vld_d   = sel_valid;
    mask_d  = sel_mask;
    s_d     = s_q;
    state_d = state_q;
    seed_d  = seed_q;
    run_d   = run_q;
    miss_d  = miss_q;
    err_d   = err_q;
    bcnt_d  = bcnt_q;
    pulse_d = 1'b0;

    if (cfg_chg) begin
      s_d     = '0;
      seed_d  = '0;
      run_d   = '0;
      miss_d  = '0;
      err_d   = '0;
      bcnt_d  = '0;
      state_d = sel_valid ? ST_SEED : ST_IDLE;
    end else if (!vld_q) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_SEED;
          seed_d  = '0;
        end
        ST_SEED: begin
          if (bit_valid) begin
            s_d    = s_upd;
            seed_d = seed_inc;
            if (seed_inc == len_q) begin
              state_d = ST_VERIFY;
              run_d   = '0;
            end
          end
        end
        ST_VERIFY: begin
          if (bit_valid) begin
            s_d = s_upd;
            if (bad) begin
              pulse_d = 1'b1;
              state_d = ST_SEED;
              seed_d  = '0;
            end else begin
              run_d = run_inc;
              if (run_inc == RUN_W'(LOCK_RUN)) begin
                state_d = ST_LOCKED;
                miss_d  = '0;
                run_d   = '0;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (bit_valid) begin
            s_d    = s_upd;
            bcnt_d = bcnt_inc;
            if (bad) begin
              pulse_d = 1'b1;
              err_d   = err_inc;
              run_d   = '0;
              miss_d  = miss_inc;
              if (miss_inc == MISS_W'(LOSS_THRESH)) begin
                state_d = ST_SEED;
                seed_d  = '0;
                miss_d  = '0;
              end
            end else begin
              run_d = run_inc;
              if (run_inc == RUN_W'(GOOD_RUN)) begin
                run_d  = '0;
                miss_d = '0;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (err_clr) begin
      err_d  = '0;
      bcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      ntaps_q <= 1'b0;
      vld_q   <= 1'b0;
      mask_q  <= '0;
      s_q     <= '0;
      state_q <= ST_IDLE;
      seed_q  <= '0;
      run_q   <= '0;
      miss_q  <= '0;
      err_q   <= '0;
      bcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      len_q   <= len_d;
      ntaps_q <= ntaps_d;
      vld_q   <= vld_d;
      mask_q  <= mask_d;
      s_q     <= s_d;
      state_q <= state_d;
      seed_q  <= seed_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      bcnt_q  <= bcnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign cfg_valid = vld_q;
  assign locked    = (state_q == ST_LOCKED);
  assign err_pulse = pulse_q;
  assign err_count = err_q;
  assign bit_count = bcnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_lfsr_fibonacci_checker.sv
// Bench for lfsr_fibonacci_checker: vector table, corner sequences,
// then random traffic checked against a history-based model.
module tb_lfsr_fibonacci_checker;

  localparam int CW  = 6;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic [2:0]    lfsr_length = 3'd0;
  logic          lfsr_n_taps = 1'b0;
  logic          err_clr = 1'b0;
  logic          cfg_valid;
  logic          locked;
  logic          err_pulse;
  logic [CW-1:0] err_count;
  logic [CW-1:0] bit_count;
  logic [1:0]    state;

  lfsr_fibonacci_checker #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .lfsr_length (lfsr_length),
    .lfsr_n_taps (lfsr_n_taps),
    .err_clr     (err_clr),
    .cfg_valid   (cfg_valid),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .bit_count   (bit_count),
    .state       (state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Reference model: received-bit history, newest first.
  int hist[$];
  int m_len, m_nt, mode, seedn, run, miss;
  int ec, bc, pu;

  function automatic int tb_mask(input int len,
                                 input int nt);
    if (nt == 0) begin
      case (len)
        2: return 'h03;
        3: return 'h06;
        4: return 'h0C;
        5: return 'h14;
        6: return 'h30;
        7: return 'h60;
        default: return 0;
      endcase
    end
    case (len)
      5: return 'h1E;
      6: return 'h36;
      7: return 'h78;
      default: return 0;
    endcase
  endfunction

  task automatic clear_hist();
    hist.delete();
    for (int k = 0; k < 8; k++) hist.push_back(0);
  endtask

  task automatic model_reset();
    clear_hist();
    m_len = 0; m_nt = 0; mode = 0; seedn = 0;
    run = 0; miss = 0; ec = 0; bc = 0; pu = 0;
  endtask

  task automatic model_step(input int len, input int nt,
                            input int b, input int v,
                            input int clr);
    int mk, pred, z, bad;
    pu = 0;
    mk = tb_mask(m_len, m_nt);
    if (len != m_len || nt != m_nt) begin
      m_len = len; m_nt = nt;
      clear_hist();
      seedn = 0; run = 0; miss = 0; ec = 0; bc = 0;
      mode = (tb_mask(len, nt) != 0) ? 1 : 0;
    end else if (mk == 0) begin
      mode = 0;
    end else if (mode == 0) begin
      mode = 1; seedn = 0;
    end else if (v != 0) begin
      pred = 0;
      for (int k = 0; k < 8; k++)
        if (((mk >> k) & 1) != 0) pred ^= hist[k];
      hist.push_front(b);
      void'(hist.pop_back());
      z = 1;
      for (int k = 0; k < m_len; k++)
        if (hist[k] != 0) z = 0;
      bad = (pred != b || z != 0) ? 1 : 0;
      if (mode == 1) begin
        seedn++;
        if (seedn == m_len) begin mode = 2; run = 0; end
      end else if (mode == 2) begin
        if (bad != 0) begin
          pu = 1; mode = 1; seedn = 0;
        end else begin
          run++;
          if (run == 8) begin
            mode = 3; miss = 0; run = 0;
          end
        end
      end else begin
        if (bc < SAT) bc++;
        if (bad != 0) begin
          pu = 1; run = 0; miss++;
          if (ec < SAT) ec++;
          if (miss == 3) begin
            mode = 1; seedn = 0; miss = 0;
          end
        end else begin
          run++;
          if (run == 16) begin run = 0; miss = 0; end
        end
      end
    end
    if (clr != 0) begin ec = 0; bc = 0; end
  endtask

  task automatic drive(input int len, input int nt,
                       input int b, input int v,
                       input int clr);
    lfsr_length = len[2:0];
    lfsr_n_taps = nt[0];
    bit_in      = b[0];
    bit_valid   = v[0];
    err_clr     = clr[0];
    model_step(len, nt, b, v, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    chk("m_state", int'(state), mode);
    chk("m_locked", int'(locked), (mode == 3) ? 1 : 0);
    chk("m_pulse", int'(err_pulse), pu);
    chk("m_err_count", int'(err_count), ec);
    chk("m_bit_count", int'(bit_count), bc);
    chk("m_cfg_valid", int'(cfg_valid),
        (tb_mask(m_len, m_nt) != 0) ? 1 : 0);
  endtask

  typedef struct {
    int b; int v; int clr;
    int st; int lk; int pu; int ec; int bc;
  } vec_t;

  function automatic vec_t mk(int b, int v, int clr,
                              int st, int lk, int pu,
                              int ec, int bc);
    vec_t r;
    r.b = b; r.v = v; r.clr = clr; r.st = st;
    r.lk = lk; r.pu = pu; r.ec = ec; r.bc = bc;
    return r;
  endfunction

  vec_t tbl[19];
  int   strm[7] = '{0, 1, 1, 1, 0, 0, 1};
  int   pos;

  task automatic feed_clean(input int n);
    for (int i = 0; i < n; i++) begin
      drive(3, 0, strm[pos % 7], 1, 0);
      pos++;
    end
  endtask

  int          pulses, seen_lock;
  int          cur_len, cur_nt, noise, b, v, clr, k;
  logic [7:0]  g, gm;
  logic        nb;
  int          vl[9] = '{2, 3, 4, 5, 6, 7, 5, 6, 7};
  int          vn[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};

  task automatic reseed_gen();
    gm = 8'(tb_mask(cur_len, cur_nt));
    g  = 8'($urandom);
    if ((g & ~(8'hFF << cur_len)) == 8'h00) g[0] = 1'b1;
  endtask

  initial begin
    // L=3 clean stream, single inversion at entry 14.
    tbl[0]  = mk(0, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 2, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 2, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, 2, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 0, 2, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 2, 0, 0, 0, 0);
    tbl[8]  = mk(1, 1, 0, 2, 0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 2, 0, 0, 0, 0);
    tbl[10] = mk(1, 1, 0, 2, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 0, 2, 0, 0, 0, 0);
    tbl[12] = mk(1, 1, 0, 3, 1, 0, 0, 0);
    tbl[13] = mk(0, 1, 0, 3, 1, 0, 0, 1);
    tbl[14] = mk(1, 1, 0, 3, 1, 1, 1, 2);
    tbl[15] = mk(1, 1, 0, 3, 1, 0, 1, 3);
    tbl[16] = mk(0, 1, 0, 3, 1, 1, 2, 4);
    tbl[17] = mk(1, 1, 0, 1, 0, 1, 3, 5);
    tbl[18] = mk(0, 0, 1, 1, 0, 0, 0, 0);

    model_reset();
    #12;
    chk("rst_outputs",
        int'({cfg_valid, locked, err_pulse,
              err_count, bit_count, state}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 1, 1, 0);
    chk("idle_state", int'(state), 0);
    chk("idle_cfg", int'(cfg_valid), 0);

    for (int i = 0; i < 19; i++) begin
      drive(3, 0, tbl[i].b, tbl[i].v, tbl[i].clr);
      chk($sformatf("t%0d_state", i), int'(state), tbl[i].st);
      chk($sformatf("t%0d_locked", i), int'(locked), tbl[i].lk);
      chk($sformatf("t%0d_pulse", i), int'(err_pulse), tbl[i].pu);
      chk($sformatf("t%0d_errcnt", i), int'(err_count), tbl[i].ec);
      chk($sformatf("t%0d_bitcnt", i), int'(bit_count), tbl[i].bc);
      chk($sformatf("t%0d_cfg", i), int'(cfg_valid), 1);
    end

    // Relock after the drop.
    pos = 16;
    feed_clean(11);
    chk("relock_locked", int'(locked), 1);
    chk("relock_err", int'(err_count), 0);

    // Clear wins over a coincident LOCKED mismatch.
    drive(3, 0, 1 - strm[pos % 7], 1, 1);
    pos++;
    chk("clr_pulse", int'(err_pulse), 1);
    chk("clr_err", int'(err_count), 0);
    chk("clr_locked", int'(locked), 1);
    feed_clean(20);
    chk("clr_relock", int'(locked), 1);
    chk("clr_err_after", int'(err_count), 2);

    // Asynchronous reset in LOCKED.
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_outputs",
        int'({cfg_valid, locked, err_pulse,
              err_count, bit_count, state}), 0);
    model_reset();
    bit_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    feed_clean(14);
    chk("post_rst_lock", int'(locked), 1);
    drive(3, 0, 1 - strm[pos % 7], 1, 0);
    pos++;
    chk("post_rst_err", int'(err_count), 1);

    // Invalid config, then switch to a legal one.
    drive(4, 1, 0, 0, 0);
    chk("inv_state", int'(state), 0);
    chk("inv_cfg", int'(cfg_valid), 0);
    chk("inv_cnt_clr", int'({err_count, bit_count}), 0);
    for (int i = 0; i < 5; i++) drive(4, 1, i & 1, 1, 0);
    chk("inv_ignored", int'(state), 0);
    drive(5, 1, 0, 0, 0);
    chk("l5_state", int'(state), 1);
    chk("l5_cfg", int'(cfg_valid), 1);
    chk("l5_cnts", int'({err_count, bit_count}), 0);

    // Dead zero line on L=7 4-tap.
    drive(7, 1, 0, 1, 0);
    pulses = 0; seen_lock = 0;
    for (int i = 0; i < 64; i++) begin
      drive(7, 1, 0, 1, 0);
      pulses += int'(err_pulse);
      if (locked) seen_lock = 1;
    end
    chk("dead_no_lock", seen_lock, 0);
    chk("dead_pulses", pulses, 8);
    chk("dead_err", int'(err_count), 0);
    check_model();

    // Random traffic against the model.
    cur_len = 7; cur_nt = 1; noise = 0;
    reseed_gen();
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          cur_len = $urandom_range(0, 7);
          cur_nt  = $urandom_range(0, 1);
        end else begin
          k = $urandom_range(0, 8);
          cur_len = vl[k]; cur_nt = vn[k];
        end
        reseed_gen();
      end
      if (noise == 0 && $urandom_range(0, 399) == 0)
        noise = 30;
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      b = $urandom_range(0, 1);
      if (v != 0) begin
        if (noise > 0) begin
          noise--;
        end else begin
          nb = ^(g & gm);
          g  = {g[6:0], nb};
          b  = int'(nb);
          if ($urandom_range(0, 24) == 0) b = 1 - b;
        end
      end
      clr = ($urandom_range(0, 1999) == 0) ? 1 : 0;
      drive(cur_len, cur_nt, b, v, clr);
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_fibonacci_checker.md
Name: lfsr_fibonacci_checker

Overview:
Serial receive-side checker for the Fibonacci LFSR stream produced by the team's LFSR generator.
- Input stream: the feedback bits the generator shifts into bit 0 each step, one bit per strobe.
- Self-synchronises: seeds its own shift register from received bits, then predicts each next bit and counts mismatches.
- Length and tap configuration are the same 3-bit length / n_taps pair the generator uses.
- Sits downstream of a pin or deserialiser input. Reports lock status and a saturating error count for bring-up and BER measurement.

Parameters:
LOCK_RUN, 8, consecutive correct predictions required in VERIFY before declaring lock
GOOD_RUN, 16, consecutive correct bits in LOCKED that clear the miss counter
LOSS_THRESH, 3, misses (without an intervening GOOD_RUN) in LOCKED that drop lock
CNT_W, 16, width of err_count and bit_count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
bit_in  in  1  received stream bit
bit_valid  in  1  bit_in is sampled on a rising clk edge while high
lfsr_length  in  3  LFSR length L (2..7)
lfsr_n_taps  in  1  0 = 2-tap mask, 1 = 4-tap mask
err_clr  in  1  synchronous clear of err_count and bit_count
cfg_valid  out  1  current length/taps select a legal mask
locked  out  1  checker is in LOCKED
err_pulse  out  1  one-cycle pulse on each mismatch (VERIFY or LOCKED)
err_count  out  CNT_W  saturating mismatch count while LOCKED
bit_count  out  CNT_W  saturating count of bits checked while LOCKED
state  out  2  encoded FSM state (debug)

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: every register clears. Shift register s[7:0]=0, state=IDLE, all counters 0, all outputs 0.
- Mask table is identical to the generator's:
  - 2-tap: L2=0x03, L3=0x06, L4=0x0C, L5=0x14, L6=0x30, L7=0x60; L0/L1 invalid.
  - 4-tap: L5=0x1E, L6=0x36, L7=0x78; L0..L4 invalid.
- Prediction: p = ^(s & mask). Compare against bit_in. On every accepted bit in SEED, VERIFY and LOCKED: s <= {s[6:0], bit_in}. The received bit is always shifted in (self-synchronising); the predicted bit is never used.
- FSM, state encoding IDLE=0, SEED=1, VERIFY=2, LOCKED=3:
  - IDLE: entered whenever the mask is invalid. cfg_valid=0. Ignores bits. Leaves for SEED with seed count 0 once the mask is valid.
  - SEED: shifts in L bits without checking. After the L-th accepted bit, moves to VERIFY with run=0.
  - VERIFY:
    - Mismatch: err_pulse, back to SEED, seed count 0. err_count is not incremented.
    - Match: run++. At run==LOCK_RUN, moves to LOCKED with miss=0 and run=0.
  - LOCKED: locked=1. Each accepted bit increments bit_count.
    - Mismatch: err_pulse, err_count++, miss++, run=0. If miss reaches LOSS_THRESH, moves to SEED and locked drops the next cycle.
    - Match: run++. At run==GOOD_RUN, miss=0 and run=0.
- Zero lock-up guard: in VERIFY/LOCKED, if the L low bits of the updated s are all zero, treat the bit as a mismatch. This prevents locking on a dead-zero line.
- Configuration change: lfsr_length/lfsr_n_taps are registered each cycle. Any change vs. the registered copy forces SEED (or IDLE if invalid) with s=0 and seed count 0. It also clears err_count and bit_count. A change takes priority over a bit accepted in the same cycle.
- Latency: outputs are registered. err_pulse, locked, state and the counters reflect the bit accepted on edge N at edge N+1 (visible after edge N).
- err_clr: clears err_count and bit_count. If it coincides with an error increment, the result is 0; clear wins.
- Counters saturate at all-ones; no wrap-around.
- bit_valid low: no state change, err_pulse=0.

Decomposition:
- Shared package: FSM state encoding, and the mask table as a function (length, n_taps) -> {valid, mask}. The generator and the checker must use the same source.
- One sub-module is natural: lfsr_mask_select (combinational mask/valid lookup), reused by both ends.
- Counters stay inline.

Test Plan:
- Lock on clean stream: L=3, n_taps=0, feed the period-7 stream 0,1,1,1,0,0,1 repeated -> locked rises after 3+8=11 accepted bits, err_count=0, state=3.
- Single error: after lock, invert one bit -> err_pulse the next cycle, err_count=1, locked stays 1. Subsequent bits: at most 2 further pulses caused by the self-sync error propagation for a 2-tap mask, so err_count<=3. Exactly LOSS_THRESH=3 pulses within 16 bits drops lock; verify the bench handles both paths.
- Lock loss: after lock, drive random bits -> locked drops after the third miss; state returns to 1, then relocks once the clean stream resumes.
- Dead line: L=7, n_taps=1, bit_in=0 constantly -> never reaches LOCKED; repeated err_pulse in VERIFY, err_count=0.
- Invalid config: L=4, n_taps=1 -> cfg_valid=0, state=0, bits ignored. Switch to L=5 -> SEED, counters cleared.
- Reset and clear: assert rst_n low mid-LOCKED -> all outputs 0 immediately (asynchronously). err_clr asserted together with a mismatch -> err_count=0.
